mips_control_fsm: RTL
=====================

# mips_control_fsm

Multi-cycle control unit for the non-pipelined MIPS datapath. It sits directly upstream of the register file. It latches the fetched instruction, decodes it, and sequences one instruction at a time through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It drives the register-file read/write addresses and `reg_write`, plus ALU, PC and data-memory controls, and stalls on memory-ready handshakes.

## Interface
Parameters:
- none; widths fixed: instruction 32, data/immediate 16, register index 5.

Ports:
- clk  in  1  system clock; everything updates on rising edge.
- reset  in  1  asynchronous, active-high.
- imem_ready  in  1  `instr` valid this cycle.
- instr  in  32  instruction word from instruction memory.
- dmem_ready  in  1  data-memory access completes this cycle.
- alu_zero  in  1  ALU zero flag, valid in EXECUTE.
- ir_write  out  1  instruction register load strobe.
- pc_write  out  1  PC update strobe.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- read_reg1  out  5  rs (IR[25:21]) to the register file.
- read_reg2  out  5  rt (IR[20:16]) to the register file.
- write_reg  out  5  rd (IR[15:11]) for R-type; rt for lw/addi.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback source: 1 = memory, 0 = ALU.
- alu_src  out  1  ALU operand B: 1 = imm, 0 = read_data2.
- alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt.
- imm  out  16  IR[15:0].
- mem_read  out  1  data-memory read request.
- mem_write  out  1  data-memory write request.
- illegal  out  1  one-cycle pulse on an unsupported instruction.
- state  out  3  current state (debug): 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEM, 4 WRITEBACK.

## Operation
- Internal 32-bit IR loads `instr` when state = FETCH and imem_ready = 1. That same cycle: ir_write = 1, pc_write = 1, pc_src = 0.
- Supported instructions:
  - R-type (opcode 0x00) with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- Transitions:
  - FETCH holds until imem_ready, then goes to DECODE.
  - DECODE:
    - j: pc_write = 1, pc_src = 2, then FETCH.
    - Unsupported opcode or funct: illegal = 1, then FETCH. No reg/mem/PC write.
    - Otherwise EXECUTE.
  - EXECUTE:
    - beq: pc_write = alu_zero, pc_src = 1, then FETCH.
    - lw/sw: go to MEM.
    - R-type/addi: go to WRITEBACK.
  - MEM: mem_read (lw) or mem_write (sw) held high until dmem_ready = 1. Then lw goes to WRITEBACK; sw goes to FETCH.
  - WRITEBACK: reg_write = 1 for exactly one cycle, then FETCH.
- Decode values:
  - alu_op: R-type from funct; lw/sw/addi = add; beq = sub.
  - alu_src = 1 for lw/sw/addi, 0 otherwise.
  - mem_to_reg = 1 only for lw.
- read_reg1, read_reg2, write_reg, imm, alu_op, alu_src and mem_to_reg are decoded from IR only. They are stable from DECODE until the next IR load.
- reg_write is 0 in DECODE and EXECUTE, so the register file samples read data in those cycles.
- Never asserted together: reg_write and mem_write; mem_read and mem_write.

## Timing
- Reset (asynchronous): state = FETCH, IR = 0, every output = 0 immediately; no strobes while reset is high.
- Reset during MEM drops mem_read/mem_write at once; no writeback follows.
- Output timing:
  - ir_write, pc_write in FETCH, and the imem_ready dependence are combinational (Mealy).
  - In MEM, mem_read/mem_write depend on state and IR only.
  - All other outputs depend on state and IR only (Moore).
- Minimum latency, FETCH edge to next FETCH, with ready signals high:
  - j / illegal: 2 cycles.
  - beq: 3 cycles.
  - sw: 4 cycles.
  - R-type/addi: 4 cycles.
  - lw: 5 cycles.
  - Each imem_ready/dmem_ready-low cycle adds one cycle.
- dmem_ready outside MEM and imem_ready outside FETCH are ignored.

## Test plan
- add $3,$1,$2 (0x00221820), imem_ready = 1:
  - Cycle 0: ir_write = 1, pc_write = 1.
  - DECODE: read_reg1 = 1, read_reg2 = 2.
  - EXECUTE: alu_op = 0, alu_src = 0.
  - Cycle 3: reg_write = 1, write_reg = 3, mem_to_reg = 0.
  - FETCH at cycle 4.
- lw $5,8($4) (0x8C850008), dmem_ready low for 3 MEM cycles:
  - mem_read high for 4 cycles; imm = 0x0008, alu_src = 1.
  - Then reg_write = 1, write_reg = 5, mem_to_reg = 1.
  - Total 8 cycles.
- beq $1,$2,4 (0x10220004):
  - alu_zero = 1: pc_write = 1, pc_src = 1 in EXECUTE, alu_op = 1.
  - alu_zero = 0: pc_write = 0 in EXECUTE.
  - No reg_write in either case.
- j (0x08000010): pc_write = 1, pc_src = 2 in DECODE; FETCH next cycle; reg_write and mem_* stay 0.
- Illegal instructions:
  - Opcode 0x3F (0xFC000000): illegal pulses one cycle in DECODE, then FETCH.
  - R-type funct 0x18 (0x00220018): same response; no writes.
- sw with dmem_ready held low, reset asserted mid-MEM:
  - mem_write falls to 0 without a clock edge; state = 0.
  - After release, no ir_write until imem_ready = 1.

Source files
------------

// File: rtl/mips_control_fsm.sv
`default_nettype none
// ============================================================================
// mips_control_fsm : multi-cycle control unit for the non-pipelined MIPS core
// Revision: 1.0
// ============================================================================
module mips_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic [31:0] instr,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [4:0]  read_reg1,
  output logic [4:0]  read_reg2,
  output logic [4:0]  write_reg,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic [15:0] imm,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam logic [2:0] c_FETCH     = 3'd0;
  localparam logic [2:0] c_DECODE    = 3'd1;
  localparam logic [2:0] c_EXECUTE   = 3'd2;
  localparam logic [2:0] c_MEM       = 3'd3;
  localparam logic [2:0] c_WRITEBACK = 3'd4;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_SLT = 6'h2A;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [31:0] r_ir;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic        w_is_r;
  logic        w_is_j;
  logic        w_is_beq;
  logic        w_is_addi;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_funct_ok;
  logic        w_legal;
  logic [2:0]  w_r_alu_op;

  logic        w_in_fetch;
  logic        w_in_decode;
  logic        w_in_execute;
  logic        w_in_mem;
  logic        w_in_wb;

  assign w_opcode  = r_ir[31:26];
  assign w_funct   = r_ir[5:0];
  assign w_is_r    = (w_opcode == c_OP_RTYPE);
  assign w_is_j    = (w_opcode == c_OP_J);
  assign w_is_beq  = (w_opcode == c_OP_BEQ);
  assign w_is_addi = (w_opcode == c_OP_ADDI);
  assign w_is_lw   = (w_opcode == c_OP_LW);
  assign w_is_sw   = (w_opcode == c_OP_SW);

  // R-type ALU operation and funct legality decoded together
  always_comb begin
    w_funct_ok = 1'b1;
    w_r_alu_op = 3'd0;
    case (w_funct)
      c_FN_ADD: w_r_alu_op = 3'd0;
      c_FN_SUB: w_r_alu_op = 3'd1;
      c_FN_AND: w_r_alu_op = 3'd2;
      c_FN_OR:  w_r_alu_op = 3'd3;
      c_FN_SLT: w_r_alu_op = 3'd4;
      default:  w_funct_ok = 1'b0;
    endcase
  end

  assign w_legal = (w_is_r && w_funct_ok) || w_is_j || w_is_beq ||
                   w_is_addi || w_is_lw || w_is_sw;

  assign w_in_fetch   = (r_state == c_FETCH);
  assign w_in_decode  = (r_state == c_DECODE);
  assign w_in_execute = (r_state == c_EXECUTE);
  assign w_in_mem     = (r_state == c_MEM);
  assign w_in_wb      = (r_state == c_WRITEBACK);

  always_comb begin
    w_next_state = c_FETCH;
    case (r_state)
      c_FETCH:     w_next_state = imem_ready ? c_DECODE : c_FETCH;
      c_DECODE:    w_next_state = (!w_legal || w_is_j) ? c_FETCH : c_EXECUTE;
      c_EXECUTE: begin
        if (w_is_beq)                w_next_state = c_FETCH;
        else if (w_is_lw || w_is_sw) w_next_state = c_MEM;
        else                         w_next_state = c_WRITEBACK;
      end
      c_MEM: begin
        if (!dmem_ready)  w_next_state = c_MEM;
        else if (w_is_lw) w_next_state = c_WRITEBACK;
        else              w_next_state = c_FETCH;
      end
      default:     w_next_state = c_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_FETCH;
      r_ir    <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_in_fetch && imem_ready)
        r_ir <= instr;
    end
  end

  // Mealy strobes are gated by reset so nothing fires while it is held
  assign ir_write = !reset && w_in_fetch && imem_ready;
  assign pc_write = !reset && ((w_in_fetch && imem_ready) ||
                               (w_in_decode && w_is_j) ||
                               (w_in_execute && w_is_beq && alu_zero));
  assign pc_src   = (w_in_decode && w_is_j)     ? 2'd2 :
                    (w_in_execute && w_is_beq)  ? 2'd1 : 2'd0;

  assign read_reg1  = r_ir[25:21];
  assign read_reg2  = r_ir[20:16];
  assign write_reg  = w_is_r ? r_ir[15:11] : r_ir[20:16];
  assign imm        = r_ir[15:0];
  assign alu_op     = w_is_r ? w_r_alu_op : (w_is_beq ? 3'd1 : 3'd0);
  assign alu_src    = w_is_lw || w_is_sw || w_is_addi;
  assign mem_to_reg = w_is_lw;

  assign reg_write = w_in_wb;
  assign mem_read  = w_in_mem && w_is_lw;
  assign mem_write = w_in_mem && w_is_sw;
  assign illegal   = w_in_decode && !w_legal;
  assign state     = r_state;

endmodule
`default_nettype wire
